wb_regfile_writer: RTL

- Consumer end of the MEM/WB pipeline register: the writeback stage and architectural register file of the 5-stage MIPS pipeline.
- Takes the registered WB_* control and data fields and selects and formats the writeback value.
- Commits that value to a 32x32 register file.
- Serves two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Exposes writeback debug state for the board display.

---
 rtl/wb_regfile_writer.sv | 116 +++++++++++
 1 files changed

// File: rtl/wb_regfile_writer.sv
// wb_regfile_writer: MIPS writeback stage and architectural register file.
// Formats the MEM/WB writeback value and commits it to a 32x32 register file.
// Serves two combinational read ports with same-cycle write-through bypass.
// Keeps debug state (last write index/data and a write counter) for the board display.
module wb_regfile_writer #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          WB_RegWrite,
   input  logic [1:0]                    WB_MemToReg,
   input  logic                          WB_halfbyte,
   input  logic                          WB_jr,
   input  logic [DATA_WIDTH-1:0]         WB_PCAddResult,
   input  logic [DATA_WIDTH-1:0]         WB_Read,
   input  logic [DATA_WIDTH-1:0]         WB_ALUResult,
   input  logic [$clog2(NUM_REGS)-1:0]   WB_RegDst,
   input  logic [$clog2(NUM_REGS)-1:0]   ReadRegister1,
   input  logic [$clog2(NUM_REGS)-1:0]   ReadRegister2,
   output logic [DATA_WIDTH-1:0]         ReadData1,
   output logic [DATA_WIDTH-1:0]         ReadData2,
   output logic [DATA_WIDTH-1:0]         WB_WriteData,
   output logic                          WB_WriteEn,
   output logic [$clog2(NUM_REGS)-1:0]   LastWriteReg,
   output logic [DATA_WIDTH-1:0]         LastWriteData,
   output logic [COUNT_WIDTH-1:0]        WriteCount
);

   localparam int IDX_WIDTH = $clog2(NUM_REGS);

   logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];
   logic [DATA_WIDTH-1:0]  write_data_s;
   logic                   write_en_s;
   logic [IDX_WIDTH-1:0]   last_write_reg_r;
   logic [DATA_WIDTH-1:0]  last_write_data_r;
   logic [COUNT_WIDTH-1:0] write_count_r;

   // Select the writeback source; halfword sign-extension only applies to memory loads.
   always_comb begin
      write_data_s = WB_ALUResult;
      case (WB_MemToReg)
         2'b00: write_data_s = WB_ALUResult;
         2'b01: begin
            if (WB_halfbyte) begin
               write_data_s = {{(DATA_WIDTH-16){WB_Read[15]}}, WB_Read[15:0]};
            end else begin
               write_data_s = WB_Read;
            end
         end
         2'b10: write_data_s = WB_PCAddResult;
         default: write_data_s = WB_ALUResult;  // reserved encoding behaves like ALU result
      endcase
   end

   // Qualify the write: jr never writes back, and $0 is hardwired to zero.
   always_comb begin
      write_en_s = WB_RegWrite & ~WB_jr & (WB_RegDst != {IDX_WIDTH{1'b0}});
   end

   // Read port 1: $0 reads zero, then same-cycle bypass, then storage.
   always_comb begin
      ReadData1 = {DATA_WIDTH{1'b0}};
      if (ReadRegister1 == {IDX_WIDTH{1'b0}}) begin
         ReadData1 = {DATA_WIDTH{1'b0}};
      end else if (write_en_s && (ReadRegister1 == WB_RegDst)) begin
         ReadData1 = write_data_s;
      end else begin
         ReadData1 = regs_r[ReadRegister1];
      end
   end

   // Read port 2: same priority as port 1, evaluated independently.
   always_comb begin
      ReadData2 = {DATA_WIDTH{1'b0}};
      if (ReadRegister2 == {IDX_WIDTH{1'b0}}) begin
         ReadData2 = {DATA_WIDTH{1'b0}};
      end else if (write_en_s && (ReadRegister2 == WB_RegDst)) begin
         ReadData2 = write_data_s;
      end else begin
         ReadData2 = regs_r[ReadRegister2];
      end
   end

   // Register file storage: cleared by reset, written on qualified commits.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (write_en_s) begin
         regs_r[WB_RegDst] <= write_data_s;
      end
   end

   // Debug state: tracks the latest committed write and counts commits (wrapping).
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         last_write_reg_r  <= {IDX_WIDTH{1'b0}};
         last_write_data_r <= {DATA_WIDTH{1'b0}};
         write_count_r     <= {COUNT_WIDTH{1'b0}};
      end else if (write_en_s) begin
         last_write_reg_r  <= WB_RegDst;
         last_write_data_r <= write_data_s;
         write_count_r     <= write_count_r + COUNT_WIDTH'(1'b1);
      end
   end

   assign WB_WriteData  = write_data_s;
   assign WB_WriteEn    = write_en_s;
   assign LastWriteReg  = last_write_reg_r;
   assign LastWriteData = last_write_data_r;
   assign WriteCount    = write_count_r;

endmodule
